// File: rtl/feeder_pkg.sv
// Shared types and constants for the global-buffer skew feeder.
// Skew-dependent drain depths are selected in the top (FEEDER_SKEW_EN).
package feeder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    localparam int LANES      = 4;
    localparam int DRAIN_SKEW = 5;
    localparam int DRAIN_FLAT = 2;
    localparam int DRAIN_W    = 3;

endpackage

// File: rtl/lane_delay.sv
// Per-lane delay line carrying {valid, data}.
// Data is forced to zero whenever valid is low.
module lane_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out
);

    logic [DEPTH-1:0][WIDTH:0] stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage[0] <= valid_in ? {1'b1, data_in} : '0;
            for (int s = 1; s < DEPTH; s++) begin
                stage[s] <= stage[s-1];
            end
        end
    end

    assign {valid_out, data_out} = stage[DEPTH-1];

endmodule

// File: rtl/gbuf_skew_feeder.sv
// Streams len rows from the global buffer into a 4x4 systolic array.
// FEEDER_SKEW_EN: lane i delayed i extra cycles (diagonal feed).
module gbuf_skew_feeder
    import feeder_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_BITS-1:0]       base_addr,
    input  logic [ADDR_BITS:0]         len,
    output logic                       busy,
    output logic                       done,
    output logic                       gbuf_wr_en,
    output logic                       gbuf_batch_mode,
    output logic [ADDR_BITS+1:0]       gbuf_index,
    input  logic [LANES*DATA_BITS-1:0] gbuf_data_in,
    output logic [LANES*DATA_BITS-1:0] lane_data,
    output logic [LANES-1:0]           lane_valid
);

`ifdef FEEDER_SKEW_EN
    localparam bit SKEW      = 1'b1;
    localparam int DRAIN_LEN = DRAIN_SKEW;
`else
    localparam bit SKEW      = 1'b0;
    localparam int DRAIN_LEN = DRAIN_FLAT;
`endif

    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_LEN - 1);
    localparam logic [ADDR_BITS:0] LEN_ONE    = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

    state_t                state;
    state_t                state_nx;
    logic [ADDR_BITS:0]    len_q;
    logic [ADDR_BITS:0]    row_k;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [DRAIN_W-1:0]    drain_q;
    logic                  rd_vld;
    logic                  last_row;
    logic                  accept;

    assign last_row = (row_k == len_q - LEN_ONE);
    assign accept   = (state == IDLE) && start && (len != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (last_row) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            row_k   <= '0;
            addr_q  <= '0;
            drain_q <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= (state == FETCH);
            if (accept) begin
                len_q  <= len;
                row_k  <= '0;
                addr_q <= base_addr;
            end
            if (state == FETCH) begin
                row_k <= row_k + LEN_ONE;
                // Address stays on the last row once issued.
                if (!last_row) begin
                    addr_q <= addr_q + ADDR_ONE;
                end else begin
                    drain_q <= DRAIN_INIT;
                end
            end
            if (state == DRAIN && drain_q != '0) begin
                drain_q <= drain_q - DRAIN_W'(1);
            end
        end
    end

    assign busy            = (state == FETCH) || (state == DRAIN);
    assign done            = (state == DONE);
    assign gbuf_wr_en      = 1'b0;
    assign gbuf_batch_mode = 1'b1;
    assign gbuf_index      = {2'b00, addr_q};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int D = SKEW ? i + 1 : 1;
        lane_delay #(
            .DEPTH(D),
            .WIDTH(DATA_BITS)
        ) u_dly (
            .clk      (clk),
            .rst_n    (rst_n),
            .valid_in (rd_vld),
            .data_in  (gbuf_data_in[i*DATA_BITS +: DATA_BITS]),
            .valid_out(lane_valid[i]),
            .data_out (lane_data[i*DATA_BITS +: DATA_BITS])
        );
    end

endmodule
